hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: maximum data-memory wait cycles before error.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the performance counters.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ID_Rs1_Addr, ID_Rs2_Addr  in  `ADDR_WIDTH  source registers of the instruction in ID.
REQ-006 ID_Use_Rs1, ID_Use_Rs2  in  1  ID instruction actually reads rs1 / rs2.
REQ-007 EX_Mem_r  in  1  EX instruction is a load.
REQ-008 EX_Rd_Addr  in  `ADDR_WIDTH  EX destination register.
REQ-009 EX_Redirect  in  1  EX resolved a taken branch or a jump.
REQ-010 Dmem_Req  in  1  MEM stage is presenting a data-memory access.
REQ-011 Dmem_Ack  in  1  data memory completes the access this cycle.
REQ-012 PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall  out  1 each  hold the corresponding register.
REQ-013 IF_ID_Flush, ID_EX_Flush  out  1 each  zero the control fields of IF/ID and ID/EX.
REQ-014 Mem_Err  out  1  sticky memory-timeout flag.
REQ-015 Stall_Cnt, Flush_Cnt  out  CNT_WIDTH each  performance counters.

Function
REQ-016 SHALL implement FSM states RUN, MEM_WAIT, ERR.
REQ-017 RUN -> MEM_WAIT when Dmem_Req=1 and Dmem_Ack=0; MEM_WAIT -> RUN on Dmem_Ack=1; MEM_WAIT -> ERR when wait counter reaches TIMEOUT-1 without ack; ERR exits only on rst.
REQ-018 Memory freeze (Dmem_Req=1 and Dmem_Ack=0, in RUN or MEM_WAIT) SHALL assert all four *_Stall outputs and deassert both flushes in the same cycle (combinational).
REQ-019 Load-use = EX_Mem_r and EX_Rd_Addr!=0 and ((ID_Use_Rs1 and ID_Rs1_Addr==EX_Rd_Addr) or (ID_Use_Rs2 and ID_Rs2_Addr==EX_Rd_Addr)); SHALL assert PC_Stall, IF_ID_Stall, ID_EX_Flush only.
REQ-020 EX_Redirect SHALL assert IF_ID_Flush and ID_EX_Flush, no stalls.
REQ-021 Priority: memory freeze > redirect > load-use; redirect with load-use SHALL give the redirect response only.
REQ-022 Ack-cycle (Dmem_Ack=1) SHALL not freeze; redirect/load-use evaluated normally that cycle.
REQ-023 Wait counter SHALL clear on entering MEM_WAIT and on ack, increment by 1 each MEM_WAIT cycle without ack.
REQ-024 In ERR all four stalls SHALL be held at 1, flushes 0, Mem_Err=1, regardless of inputs.
REQ-025 Stall_Cnt SHALL increment by 1 each cycle PC_Stall=1; Flush_Cnt each cycle ID_EX_Flush=1; both saturate at all-ones.
REQ-026 Stall/flush outputs SHALL be combinational from state and inputs; Mem_Err and counters registered.

Reset
REQ-027 rst=1 at a rising edge SHALL force state RUN, wait counter 0, Mem_Err 0, Stall_Cnt 0, Flush_Cnt 0, including mid-MEM_WAIT and in ERR.
REQ-028 While rst=1, all stall and flush outputs SHALL be 0.

Verification
REQ-029 EX_Mem_r=1, EX_Rd_Addr=5, ID_Rs2_Addr=5, ID_Use_Rs2=1 -> PC_Stall=IF_ID_Stall=ID_EX_Flush=1, others 0; Stall_Cnt and Flush_Cnt +1 next edge.
REQ-030 Same as REQ-029 but EX_Rd_Addr=0 or ID_Use_Rs2=0 -> all outputs 0.
REQ-031 EX_Redirect=1 with load-use active -> IF_ID_Flush=ID_EX_Flush=1, all stalls 0.
REQ-032 Dmem_Req=1, Dmem_Ack=0 for 3 cycles then ack, EX_Redirect=1 throughout -> 3 cycles all stalls 1/flushes 0, ack cycle flushes 1, state RUN, Stall_Cnt=3.
REQ-033 TIMEOUT=4, Dmem_Req=1 with no ack -> ERR entered, Mem_Err=1 after 4 wait cycles, stalls stuck at 1; rst=1 one edge -> all outputs 0, counters 0.
REQ-034 Force PC_Stall continuously with CNT_WIDTH=4 -> Stall_Cnt reaches 15 and stays 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, redirect flush and load-use stall
// resolution, with a data-memory timeout trap and saturating stall/flush counters.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif

module hazard_ctrl #(
  parameter int TIMEOUT   = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`ADDR_WIDTH-1:0] ID_Rs1_Addr,
  input  logic [`ADDR_WIDTH-1:0] ID_Rs2_Addr,
  input  logic                   ID_Use_Rs1,
  input  logic                   ID_Use_Rs2,
  input  logic                   EX_Mem_r,
  input  logic [`ADDR_WIDTH-1:0] EX_Rd_Addr,
  input  logic                   EX_Redirect,
  input  logic                   Dmem_Req,
  input  logic                   Dmem_Ack,
  output logic                   PC_Stall,
  output logic                   IF_ID_Stall,
  output logic                   ID_EX_Stall,
  output logic                   EX_MEM_Stall,
  output logic                   IF_ID_Flush,
  output logic                   ID_EX_Flush,
  output logic                   Mem_Err,
  output logic [CNT_WIDTH-1:0]   Stall_Cnt,
  output logic [CNT_WIDTH-1:0]   Flush_Cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  mem_err_q;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, flush_cnt_q;

  logic mem_freeze;
  logic load_use;

  assign mem_freeze = Dmem_Req && !Dmem_Ack && (state_q != ERR);
  assign load_use   = EX_Mem_r && (EX_Rd_Addr != '0) &&
                      ((ID_Use_Rs1 && (ID_Rs1_Addr == EX_Rd_Addr)) ||
                       (ID_Use_Rs2 && (ID_Rs2_Addr == EX_Rd_Addr)));

  // Hazard response, highest priority first; everything is quiet while in reset.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    PC_Stall     = 1'b0;
    IF_ID_Stall  = 1'b0;
    ID_EX_Stall  = 1'b0;
    EX_MEM_Stall = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    if (!rst) begin
      if ((state_q == ERR) || mem_freeze) begin
        PC_Stall     = 1'b1;
        IF_ID_Stall  = 1'b1;
        ID_EX_Stall  = 1'b1;
        EX_MEM_Stall = 1'b1;
      end else if (EX_Redirect) begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Flush  = 1'b1;
      end else if (load_use) begin
        PC_Stall     = 1'b1;
        IF_ID_Stall  = 1'b1;
        ID_EX_Flush  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        if (mem_freeze) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (Dmem_Ack) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_d == ERR) mem_err_q <= 1'b1;
      // Counters saturate at all-ones rather than wrap.
      if (PC_Stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if (ID_EX_Flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign Mem_Err   = mem_err_q;
  assign Stall_Cnt = stall_cnt_q;
  assign Flush_Cnt = flush_cnt_q;

endmodule
